mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle control FSM for the 8-bit MIPS datapath. Fetches each 32-bit instruction as four bytes.
//  Decodes op/funct and drives every datapath mux select and write enable (mux, mux4 selects, IR/PC/RF/mem).
//  Moore FSM with one registered state. Outputs decode from state; pcen also uses zero, alucont also uses funct.
// PARAMETERS
//  (none) -- widths fixed by the 8-bit datapath; encodings live in ctrl_pkg
// PORTS
//  clk       in   1  system clock; single clock domain, rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  op        in   6  IR[31:26] opcode
//  funct     in   6  IR[5:0] R-type function
//  zero      in   1  ALU zero flag, same cycle
//  memread   out  1  memory read strobe
//  memwrite  out  1  memory write strobe
//  iord      out  1  address mux: 0=PC, 1=ALUOut
//  irwrite   out  4  one-hot IR byte load enable, bit n loads IR byte n
//  alusrca   out  1  ALU A mux: 0=PC, 1=reg A
//  alusrcb   out  2  ALU B mux4 sel: 00=reg B, 01=const 1, 10=sign-ext imm, 11=imm<<2
//  pcsrc     out  2  PC mux4 sel: 00=ALU result, 01=ALUOut, 10=jump target
//  pcen      out  1  PC load = pcwrite | (branch & zero)
//  regwrite  out  1  register file write enable
//  regdst    out  1  write-reg mux: 0=rt, 1=rd
//  memtoreg  out  1  write-data mux: 0=ALUOut, 1=MDR
//  alucont   out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
//  done      out  1  1-cycle pulse in the final state of each instruction
// BEHAVIOUR
//  Reset: state<=FETCH1 asynchronously. While rst_n=0, memwrite/irwrite/pcen/regwrite/done are forced to 0.
//    All other outputs hold FETCH1 values: memread=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucont=010.
//  Unlisted outputs are 0 in every state. aluop is internal: 00=add, 01=sub, 10=funct.
//  FETCH1..4 -> next FETCH, FETCH4->DECODE: memread, irwrite=0001/0010/0100/1000, alusrca=0, alusrcb=01, aluop=00, pcwrite.
//  DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target to ALUOut). Next state by op:
//    100000 LB, 101000 SB -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000010 -> JEX; other -> FETCH1.
//  MEMADR: alusrca=1, alusrcb=10, aluop=00 -> LBRD if op=LB, else SBWR
//  LBRD: memread, iord=1 -> LBWR.  LBWR: regwrite, memtoreg=1, regdst=0, done -> FETCH1
//  SBWR: memwrite, iord=1, done -> FETCH1
//  RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWR.  RTYPEWR: regwrite, regdst=1, done -> FETCH1
//  BEQEX: alusrca=1, alusrcb=00, aluop=01, branch, pcsrc=01, done -> FETCH1
//  JEX: pcwrite, pcsrc=10, done -> FETCH1
//  alucont when aluop=10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
//  Cycle counts incl. 4 fetch + decode: LB 8, SB 7, R 7, BEQ 6, J 6, ADDI 7; illegal op 5 (no writes after fetch).
//  op/funct are sampled only in DECODE/MEMADR and RTYPEEX; changes elsewhere are ignored.
//  Reset mid-instruction aborts it with no partial RF/mem write after rst_n rises; the first fetch restarts at FETCH1.
// CONFIGURATION
//  CTRL_ADDI_EN defined: op 001000 in DECODE -> ADDIEX, then ADDIWR -> FETCH1.
//    ADDIEX: alusrca=1, alusrcb=10, aluop=00.
//    ADDIWR: regwrite, regdst=0, memtoreg=0, done.
//  CTRL_ADDI_EN undefined: the ADDI states do not exist; op 001000 is illegal -> FETCH1.
// STRUCTURE
//  ctrl_pkg: state encoding (4-bit localparams), opcode and funct constants, aluop codes, alusrcb/pcsrc codes.
//  Sub-module alu_ctrl: combinational aluop+funct -> alucont. The FSM lives in mc_controller.
// TESTING
//  rst_n=0 mid-RTYPEWR -> regwrite=0 at once; after release, state=FETCH1, irwrite=0001, pcen=1.
//  R-type op=000000 funct=100010 -> irwrite 0001,0010,0100,1000 in cycles 1-4.
//    -> RTYPEEX alucont=110; RTYPEWR regwrite=1, regdst=1, done=1 in cycle 7.
//  LB op=100000 -> MEMADR alusrcb=10; LBRD memread=1, iord=1; LBWR regwrite=1, memtoreg=1; done in cycle 8.
//  BEQ op=000100, zero=1 -> BEQEX pcen=1, pcsrc=01; with zero=0 -> pcen=0; both take 6 cycles.
//  op=001000 -> with CTRL_ADDI_EN: regwrite=1 in cycle 7, alucont=010;
//    without CTRL_ADDI_EN: FETCH1 after DECODE, no regwrite, done never asserted.
//  SB then J back-to-back -> memwrite=1 only in SBWR; JEX pcsrc=10, pcen=1; done pulses in cycles 7 and 13.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, opcode/funct constants and mux/alu codes for the multicycle controller
package ctrl_pkg;
  localparam logic [3:0] s_fetch1 = 4'd0, s_fetch2 = 4'd1, s_fetch3 = 4'd2, s_fetch4 = 4'd3;
  localparam logic [3:0] s_decode = 4'd4, s_memadr = 4'd5, s_lbrd = 4'd6, s_lbwr = 4'd7;
  localparam logic [3:0] s_sbwr = 4'd8, s_rtypeex = 4'd9, s_rtypewr = 4'd10, s_beqex = 4'd11;
  localparam logic [3:0] s_jex = 4'd12, s_addiex = 4'd13, s_addiwr = 4'd14;
  localparam logic [5:0] op_lb = 6'b100000, op_sb = 6'b101000, op_rtype = 6'b000000;
  localparam logic [5:0] op_beq = 6'b000100, op_j = 6'b000010, op_addi = 6'b001000;
  localparam logic [5:0] fn_add = 6'b100000, fn_sub = 6'b100010, fn_and = 6'b100100;
  localparam logic [5:0] fn_or = 6'b100101, fn_slt = 6'b101010;
  localparam logic [1:0] aluop_add = 2'b00, aluop_sub = 2'b01, aluop_fn = 2'b10;
  localparam logic [1:0] srcb_b = 2'b00, srcb_one = 2'b01, srcb_imm = 2'b10, srcb_imm4 = 2'b11;
  localparam logic [1:0] pc_alu = 2'b00, pc_aluout = 2'b01, pc_jump = 2'b10;
  localparam logic [2:0] ac_add = 3'b010, ac_sub = 3'b110, ac_and = 3'b000, ac_or = 3'b001, ac_slt = 3'b111;
endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: maps aluop and R-type funct to the ALU control code
module alu_ctrl
  import ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);
  always_comb begin
    alucont = aluop == aluop_sub ? ac_sub :
              aluop != aluop_fn  ? ac_add :
              funct == fn_sub    ? ac_sub :
              funct == fn_and    ? ac_and :
              funct == fn_or     ? ac_or  :
              funct == fn_slt    ? ac_slt : ac_add;
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the 8-bit MIPS datapath
// Optional ADDI support is enabled by defining CTRL_ADDI_EN.
module mc_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [2:0] alucont,
  output logic       done
);
  logic [3:0] state;
  logic [1:0] aluop;
  logic [3:0] irw;
  logic       mw, pw, br, rw, dn;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= s_fetch1;
    else begin
      case (state)
        s_fetch1, s_fetch2, s_fetch3: state <= state + 4'd1;
        s_fetch4:  state <= s_decode;
        s_decode:  state <= (op == op_lb || op == op_sb) ? s_memadr :
                            op == op_rtype ? s_rtypeex :
                            op == op_beq   ? s_beqex :
                            op == op_j     ? s_jex :
`ifdef CTRL_ADDI_EN
                            op == op_addi  ? s_addiex :
`endif
                            s_fetch1;
        s_memadr:  state <= op == op_lb ? s_lbrd : s_sbwr;
        s_lbrd:    state <= s_lbwr;
        s_rtypeex: state <= s_rtypewr;
`ifdef CTRL_ADDI_EN
        s_addiex:  state <= s_addiwr;
`endif
        default:   state <= s_fetch1;
      endcase
    end
  end
  always_comb begin
    memread = 1'b0;
    iord = 1'b0;
    irw = 4'b0000;
    alusrca = 1'b0;
    alusrcb = srcb_b;
    pcsrc = pc_alu;
    aluop = aluop_add;
    regdst = 1'b0;
    memtoreg = 1'b0;
    mw = 1'b0;
    pw = 1'b0;
    br = 1'b0;
    rw = 1'b0;
    dn = 1'b0;
    case (state)
      s_fetch1, s_fetch2, s_fetch3, s_fetch4: begin
        memread = 1'b1;
        irw = 4'b0001 << state[1:0];
        alusrcb = srcb_one;
        pw = 1'b1;
      end
      s_decode: alusrcb = srcb_imm4;
      s_memadr: begin
        alusrca = 1'b1;
        alusrcb = srcb_imm;
      end
      s_lbrd: begin
        memread = 1'b1;
        iord = 1'b1;
      end
      s_lbwr: begin
        rw = 1'b1;
        memtoreg = 1'b1;
        dn = 1'b1;
      end
      s_sbwr: begin
        mw = 1'b1;
        iord = 1'b1;
        dn = 1'b1;
      end
      s_rtypeex: begin
        alusrca = 1'b1;
        aluop = aluop_fn;
      end
      s_rtypewr: begin
        rw = 1'b1;
        regdst = 1'b1;
        dn = 1'b1;
      end
      s_beqex: begin
        alusrca = 1'b1;
        aluop = aluop_sub;
        br = 1'b1;
        pcsrc = pc_aluout;
        dn = 1'b1;
      end
      s_jex: begin
        pw = 1'b1;
        pcsrc = pc_jump;
        dn = 1'b1;
      end
`ifdef CTRL_ADDI_EN
      s_addiex: begin
        alusrca = 1'b1;
        alusrcb = srcb_imm;
      end
      s_addiwr: begin
        rw = 1'b1;
        dn = 1'b1;
      end
`endif
      default: ;
    endcase
  end
  // write strobes are held off while reset is asserted so an aborted instruction leaves no trace
  assign memwrite = rst_n & mw;
  assign irwrite  = {4{rst_n}} & irw;
  assign pcen     = rst_n & (pw | (br & zero));
  assign regwrite = rst_n & rw;
  assign done     = rst_n & dn;
  alu_ctrl u_alu_ctrl (
    .aluop  (aluop),
    .funct  (funct),
    .alucont(alucont)
  );
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: instruction-level model of the controller checked every cycle, plus literal spot checks
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       memread, memwrite, iord, alusrca, pcen, regwrite, regdst, memtoreg, done;
  logic [3:0] irwrite;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alucont(alucont), .done(done)
  );
  always #5 clk = ~clk;
  // bit map: 19 memread, 18 memwrite, 17 iord, 16:13 irwrite, 12 alusrca, 11:10 alusrcb,
  // 9:8 pcsrc, 7 pcen, 6 regwrite, 5 regdst, 4 memtoreg, 3:1 alucont, 0 done
  logic [19:0] act;
  assign act = {memread, memwrite, iord, irwrite, alusrca, alusrcb, pcsrc, pcen,
                regwrite, regdst, memtoreg, alucont, done};
  localparam logic [19:0] RST_V = 20'b1_0_0_0000_0_01_00_0_0_0_0_010_0;
  int checks = 0;
  int errors = 0;
  logic [19:0] exp_v = RST_V;
  logic        exp_valid = 1'b0;
  string       tag = "reset";
  int          step = 0;
  logic [19:0] cap [8];
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s step %0d act=%h exp=%h", tag, step, act, exp_v);
      end
    end
  end
  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  function automatic int len_of(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000: return 7;
      6'b000000: return 7;
      6'b000100: return 6;
      6'b000010: return 6;
`ifdef CTRL_ADDI_EN
      6'b001000: return 7;
`endif
      default:   return 5;
    endcase
  endfunction
  function automatic logic [19:0] model(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
    logic mr, mw, io, sa, pe, rw, rd, mt, dn;
    logic [3:0] irw;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    int j;
    mr = 0; mw = 0; io = 0; sa = 0; pe = 0; rw = 0; rd = 0; mt = 0; dn = 0;
    irw = 4'b0000; sb = 2'b00; ps = 2'b00; ac = 3'b010; j = k - 5;
    if (k < 4) begin
      mr = 1; irw = 4'b0001 << k; sb = 2'b01; pe = 1;
    end else if (k == 4) sb = 2'b11;
    else begin
      case (o)
        6'b100000, 6'b101000: begin
          if (j == 0) begin sa = 1; sb = 2'b10; end
          else if (o == 6'b101000) begin mw = 1; io = 1; dn = 1; end
          else if (j == 1) begin mr = 1; io = 1; end
          else begin rw = 1; mt = 1; dn = 1; end
        end
        6'b000000: begin
          if (j == 0) begin sa = 1; ac = alu_of(f); end
          else begin rw = 1; rd = 1; dn = 1; end
        end
        6'b000100: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; dn = 1; end
        6'b000010: begin pe = 1; ps = 2'b10; dn = 1; end
        default: begin
          if (j == 0) begin sa = 1; sb = 2'b10; end
          else begin rw = 1; dn = 1; end
        end
      endcase
    end
    return {mr, mw, io, irw, sa, sb, ps, pe, rw, rd, mt, ac, dn};
  endfunction
  task automatic chk(input string n, input logic [19:0] a, input logic [19:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  // runs one instruction from FETCH1; abort_k >= 0 pulls reset during that step
  task automatic run(input string n, input logic [5:0] i_op, input logic [5:0] i_fn, input logic i_z, input int abort_k);
    tag = n;
    for (int i = 0; i < 8; i++) cap[i] = '0;
    for (int k = 0; k < len_of(i_op); k++) begin
      step = k;
      op = (k == 4 || k == 5) ? i_op : 6'($urandom);
      funct = (k == 4 || k == 5) ? i_fn : 6'($urandom);
      zero = (k == 5) ? i_z : 1'($urandom_range(0, 1));
      exp_v = model(i_op, i_fn, i_z, k);
      exp_valid = 1'b1;
      @(negedge clk);
      #1 cap[k] = act;
      if (k == abort_k) begin
        rst_n = 1'b0;
        exp_v = RST_V;
        #1 chk({n, "_rst_regwrite"}, {19'd0, regwrite}, 20'd0);
        chk({n, "_rst_vec"}, act, RST_V);
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    exp_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_vec", act, RST_V);
    rst_n = 1'b1;
    run("r_sub", 6'b000000, 6'b100010, 1'b0, -1);
    for (int k = 0; k < 4; k++) chk("r_sub_irwrite", {16'd0, cap[k][16:13]}, 20'd1 << k);
    chk("r_sub_alucont", {17'd0, cap[5][3:1]}, 20'b110);
    chk("r_sub_wr", {17'd0, cap[6][6], cap[6][5], cap[6][0]}, 20'b111);
    run("r_add", 6'b000000, 6'b100000, 1'b0, -1);
    run("r_and", 6'b000000, 6'b100100, 1'b1, -1);
    run("r_or", 6'b000000, 6'b100101, 1'b0, -1);
    run("r_slt", 6'b000000, 6'b101010, 1'b1, -1);
    run("r_other", 6'b000000, 6'b000111, 1'b0, -1);
    chk("r_other_alucont", {17'd0, cap[5][3:1]}, 20'b010);
    run("lb", 6'b100000, 6'b000000, 1'b0, -1);
    chk("lb_srcb", {18'd0, cap[5][11:10]}, 20'b10);
    chk("lb_rd", {18'd0, cap[6][19], cap[6][17]}, 20'b11);
    chk("lb_wr", {17'd0, cap[7][6], cap[7][4], cap[7][0]}, 20'b111);
    run("sb", 6'b101000, 6'b000000, 1'b0, -1);
    chk("sb_memwrite", {13'd0, cap[6][18], cap[5][18], cap[4][18], cap[3][18], cap[2][18], cap[1][18], cap[0][18]}, 20'b1000000);
    chk("sb_done", {13'd0, cap[6][0], cap[5][0], cap[4][0], cap[3][0], cap[2][0], cap[1][0], cap[0][0]}, 20'b1000000);
    run("j", 6'b000010, 6'b000000, 1'b0, -1);
    chk("j_jex", {16'd0, cap[5][9:8], cap[5][7], cap[5][0]}, 20'b1011);
    run("beq_z1", 6'b000100, 6'b000000, 1'b1, -1);
    chk("beq_z1_pc", {17'd0, cap[5][9:8], cap[5][7]}, 20'b011);
    run("beq_z0", 6'b000100, 6'b000000, 1'b0, -1);
    chk("beq_z0_pcen", {19'd0, cap[5][7]}, 20'd0);
    run("addi", 6'b001000, 6'b000000, 1'b0, -1);
`ifdef CTRL_ADDI_EN
    chk("addi_wr", {16'd0, cap[6][6], cap[5][3:1]}, 20'b1010);
`else
    chk("addi_illegal", {15'd0, cap[4][6], cap[4][0], cap[3][0], cap[2][0], cap[1][0]}, 20'd0);
`endif
    run("illegal", 6'b111111, 6'b000000, 1'b0, -1);
    run("abort", 6'b000000, 6'b100000, 1'b0, 6);
    chk("abort_pre_wr", {19'd0, cap[6][6]}, 20'd1);
    run("after_abort", 6'b000000, 6'b100101, 1'b0, -1);
    chk("after_abort_fetch1", {15'd0, cap[0][16:13], cap[0][7]}, 20'b00011);
    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
